// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline registers: the flush FSM state
// encoding and the width of the post-flush hold counter.
package cpu_pipe_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pipe_state_t;

    localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/pipe_zero_stage_reg_if.sv
// Bundle of the handshake, payload and status signals of pipe_zero_stage_reg.
// The master side drives the payload and the stall/flush controls. The slave
// side is the pipeline register itself.
interface pipe_zero_stage_reg_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);

    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] dout;
    logic             busy_flush;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output in_valid, din, stall, flush,
        input  out_valid, dout, busy_flush, bubble_cnt
    );

    modport slave (
        input  in_valid, din, stall, flush,
        output out_valid, dout, busy_flush, bubble_cnt
    );

endinterface

// File: rtl/pipe_zero_slot.sv
// A single {valid, data} pipeline slot.
// clear zeroes the slot, and it overrides hold. hold keeps the current contents.
// Otherwise the slot loads the incoming word. The data is forced to zero when
// the incoming valid is low, so a bubble always carries literal zeros.
module pipe_zero_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    // Slot register: reset/clear to an empty slot, else hold, else load-or-zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (!hold) begin
            vld <= load_vld;
            dat <= load_vld ? load_dat : '0;
        end
    end

endmodule

// File: rtl/pipe_zero_stage_reg.sv
// Stallable, flushable pipeline register: DEPTH {valid, data} slots.
// Invalid slots always carry all-zero data.
// After a flush, a programmable window of FLUSH_HOLD non-stalled cycles
// forces bubbles into stage 0.
// Optional feature: define PIPE_BUBBLE_STATS_EN to build the saturating
// bubble_cnt counter. Without it, bubble_cnt is tied to zero.
module pipe_zero_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 1,
    parameter int FLUSH_HOLD = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_zero_stage_reg_if.slave  bus
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(FLUSH_HOLD);

    pipe_state_t            state;
    logic [HOLD_CNT_W-1:0]  hold_cnt;
    logic                   accept;

    logic                   vld_p [DEPTH];
    logic [WIDTH-1:0]       dat_p [DEPTH];

    // While in HOLD, the input is squashed regardless of in_valid.
    assign accept = bus.in_valid & (state == ST_RUN);

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            logic             ld_vld;
            logic [WIDTH-1:0] ld_dat;

            // Stage boundary: stage 0 takes the gated input, later stages take their predecessor
            if (i == 0) begin : g_head
                assign ld_vld = accept;
                assign ld_dat = bus.din;
            end else begin : g_tail
                assign ld_vld = vld_p[i-1];
                assign ld_dat = dat_p[i-1];
            end

            pipe_zero_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk      (clk),
                .reset    (reset),
                .clear    (bus.flush),
                .hold     (bus.stall),
                .load_vld (ld_vld),
                .load_dat (ld_dat),
                .vld      (vld_p[i]),
                .dat      (dat_p[i])
            );
        end
    endgenerate

    // Flush FSM: a flush enters or re-arms HOLD, and HOLD counts down on non-stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
        end else if (bus.flush) begin
            if (FLUSH_HOLD > 0) begin
                state    <= ST_HOLD;
                hold_cnt <= HOLD_LOAD;
            end
        end else if (state == ST_HOLD && !bus.stall) begin
            if (hold_cnt <= HOLD_CNT_W'(1)) begin
                state    <= ST_RUN;
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign bus.out_valid  = vld_p[DEPTH-1];
    assign bus.dout       = dat_p[DEPTH-1];
    assign bus.busy_flush = (state == ST_HOLD);

`ifdef PIPE_BUBBLE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             bubble_in;
    logic [CNT_W-1:0] bubble_cnt_q;

    // Stage 0 loads a bubble on a flush, or when it advances without accepting a word.
    assign bubble_in = bus.flush | (~bus.stall & ~accept);

    // Saturating bubble counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else if (bubble_in && bubble_cnt_q != CNT_MAX) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`else
    assign bus.bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipe_zero_stage_reg.md
# pipe_zero_stage_reg

Parametrised pipeline register for the CPU datapath. It carries a WIDTH-bit payload through DEPTH register stages with a valid bit per stage. It supports stall (hold), flush (zero every stage), and a programmable post-flush bubble window. Invalid slots always carry all-zero data, so downstream stages see literal zeros for bubbles. It sits between CPU pipeline stages wherever a squashable, stallable register is needed.

## Interface
- WIDTH, 64, payload width in bits (≥1)
- DEPTH, 1, number of register stages (1..4)
- FLUSH_HOLD, 0, extra cycles of forced bubbles after a flush (0..15)
- CNT_W, 16, bubble counter width (only meaningful with the stats feature)

- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  din carries a real instruction/operand this cycle
- din  in  WIDTH  payload into stage 0
- stall  in  1  hold all stages
- flush  in  1  squash all stages
- out_valid  out  1  valid bit of the last stage
- dout  out  WIDTH  data of the last stage; all zeros whenever out_valid=0
- busy_flush  out  1  high while in the HOLD state (input being forced to a bubble)
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted (see Configuration)

## Operation
- Each stage i holds {v[i], d[i]}. Stage 0 is fed from the input; stage i is fed from stage i-1. dout = d[DEPTH-1]; out_valid = v[DEPTH-1].
- Zero-on-invalid: stage 0 captures d = (accept ? din : 0) and v = accept, where accept = in_valid & (state==RUN).
- Priority per cycle: reset > flush > stall > advance.
  - flush=1: every v=0 and every d=0, regardless of stall.
  - stall=1 (no flush): all stages hold; the input is dropped.
  - Otherwise all stages shift by one.
- FSM states:
  - RUN: normal operation.
  - HOLD: stage 0 input is forced to a bubble and in_valid is ignored.
- FSM transitions:
  - RUN→HOLD on flush when FLUSH_HOLD>0; hold_cnt loads FLUSH_HOLD.
  - In HOLD, hold_cnt decrements on each cycle with stall=0 and flush=0. When it decrements from 1, the next state is RUN.
  - flush while in HOLD reloads hold_cnt to FLUSH_HOLD.
  - When FLUSH_HOLD=0, the FSM never leaves RUN.
- busy_flush = (state==HOLD).
- Reset values: all v=0, all d=0, state=RUN, hold_cnt=0, out_valid=0, dout=0, busy_flush=0, bubble_cnt=0.
- Reset asserted mid-HOLD or with the pipe full takes effect at the next edge; no partial state survives.

## Timing
- Latency: a word accepted at edge N appears on dout after edge N+DEPTH-1, i.e. DEPTH edges after it is presented. This assumes no stall; each stalled cycle adds one.
- Throughput: one word per non-stalled cycle.
- Flush is effective at the next edge: out_valid=0 and dout=0 in the following cycle.
- With FLUSH_HOLD=K, the first input that can be accepted after a flush is on the (K+1)th non-stalled cycle following the flush edge.
- All outputs are registered or decoded directly from registers; there is no combinational path from inputs to outputs.

## Configuration
- PIPE_BUBBLE_STATS_EN defined:
  - bubble_cnt increments by 1 on each cycle where stage 0 loads a bubble: flush=1, or (stall=0 and accept=0).
  - It saturates at 2^CNT_W−1 and clears only on reset.
- PIPE_BUBBLE_STATS_EN not defined:
  - The counter logic is removed and bubble_cnt is tied to constant 0.
  - The port list is unchanged.

## Structure
- Shared package cpu_pipe_pkg contains:
  - State encoding constants (ST_RUN=1'b0, ST_HOLD=1'b1).
  - The hold_cnt width constant (4 bits).
- Sub-module pipe_zero_slot: one {valid, data} register with clear, hold, and load-or-zero inputs. It is instantiated DEPTH times via generate.
- The FSM, hold counter, and stats counter live in the top module.

## Test plan
Unless stated otherwise, WIDTH=64, DEPTH=2, FLUSH_HOLD=2, stats enabled.
1. Reset, then idle → out_valid=0, dout=0, busy_flush=0, bubble_cnt=0.
2. in_valid=1, din=64'hDEADBEEF_00000001 presented for one cycle, followed by in_valid=0 with din=64'hFFFF_FFFF_FFFF_FFFF → the first word is on dout with out_valid=1 after 2 edges. The next cycle gives dout=0, out_valid=0.
3. Pipe full (A,B), stall=1 for 3 cycles → dout=A is unchanged throughout. After stall is released, dout=B on the next edge.
4. flush=1 together with stall=1, pipe full → the next cycle has out_valid=0, dout=0, busy_flush=1. in_valid=1 is ignored for 2 non-stalled cycles; the third input is accepted.
5. reset asserted during HOLD → the next cycle has busy_flush=0, and an input presented that cycle is accepted.
6. CNT_W=4, in_valid=0 for 20 non-stalled cycles → bubble_cnt saturates at 15. Built without PIPE_BUBBLE_STATS_EN, bubble_cnt stays 0.
